cim_func_stream: RTL and testbench

- Output functional unit for a crossbar (CIM) layer, second generation.
- Walks every crossbar output address and selects the horizontal tile holding each output element.
- Sums signed partial results from all vertical tiles, then requantises (arithmetic right shift, saturate) and streams elements to the next layer over a valid/ready interface.
- Sits between a layer's CIM tile array and the next layer's input buffer; the start/busy handshake is shared with the layer controllers.

---
 rtl/cim_func_pkg.sv | 32 +++
 rtl/cim_requant.sv | 52 +++++
 rtl/cim_func_stream.sv | 155 +++++++++++++++
 tb/tb_cim_func_stream.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_func_pkg.sv
// Shared types and helpers for the CIM output functional unit.
//
// Contents:
//   t_cim_func_state : FSM state encoding for cim_func_stream.
//   ceil_div         : ceiled integer division, used to size tile counts.
//   saturate         : clamps a 64-bit signed value to a w-bit signed range.
package cim_func_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    DRAIN,
    HANDOFF
  } t_cim_func_state;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // The result always fits in w signed bits, so callers may truncate it.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/cim_requant.sv
// Combinational requantiser for one output element.
//
// Sums the signed partial results of all vertical tiles at full precision,
// optionally clamps negative sums to zero, shifts right arithmetically and
// saturates to out_width signed bits.
//
// Optional feature: define CIM_FUNC_RELU_EN to clamp negative sums to 0
// before the shift (ReLU). Without it the sum is passed through signed.
//
// Ports:
//   tiles  in  v_cim_tiles*in_width  packed partial results, tile v at [v*in_width +: in_width]
//   shift  in  5                     arithmetic right shift amount
//   result out out_width             saturated signed element
module cim_requant
  import cim_func_pkg::*;
#(
  parameter int v_cim_tiles = 1,
  parameter int in_width    = 16,
  parameter int out_width   = 8
) (
  input  logic [v_cim_tiles*in_width-1:0] tiles,
  input  logic [4:0]                      shift,
  output logic [out_width-1:0]            result
);

  // One guard bit beyond the tree growth, so the sum never overflows.
  localparam int acc_width = in_width + $clog2(v_cim_tiles) + 1;

  logic signed [acc_width-1:0] sum;
  logic signed [acc_width-1:0] clamped;
  logic signed [acc_width-1:0] shifted;
  logic signed [63:0]          wide;

  always_comb begin
    sum = '0;
    for (int v = 0; v < v_cim_tiles; v++) begin
      sum = sum + $signed({{(acc_width - in_width){tiles[v*in_width + in_width - 1]}},
                           tiles[v*in_width +: in_width]});
    end

    clamped = sum;
`ifdef CIM_FUNC_RELU_EN
    if (sum[acc_width-1]) clamped = '0;
`endif

    // Shifts of acc_width or more fill with the sign bit, giving 0 or -1.
    shifted = clamped >>> shift;
    wide    = {{(64 - acc_width){shifted[acc_width-1]}}, shifted};
    result  = out_width'(saturate(wide, out_width));
  end

endmodule

// File: rtl/cim_func_stream.sv
// Output functional unit for one crossbar (CIM) layer.
//
// After the layer's CIM compute finishes, walks every output element n,
// presents crossbar address n mod xbar_size, picks horizontal tile
// n / xbar_size, requantises the summed vertical tiles and streams the
// result to the next layer. When the last element has been accepted it
// releases the crossbar and pulses o_start_next once the next layer is free.
//
// Optional feature: CIM_FUNC_RELU_EN (see cim_requant); port list unchanged.
//
// Handshake: an element moves from o_data to the consumer on any rising
// clk edge where o_valid and i_ready are both high. o_data is held stable
// while o_valid=1 and i_ready=0; a new element is loaded whenever the output
// register is empty or being emptied in the same cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       pulse, CIM compute for this layer finished (IDLE only)
//   i_cim_busy    crossbar array still computing/writing
//   i_next_busy   next layer's functional unit busy
//   i_shift       requantisation shift, captured when i_start is accepted
//   i_data        tile outputs at o_cim_addr; tile (h,v) at [(h*v_cim_tiles+v)*in_width +: in_width]
//   o_cim_addr    crossbar output address
//   o_busy        unit owns the crossbar outputs
//   o_data        requantised element
//   o_valid       o_data valid
//   i_ready       downstream accepts o_data
//   o_start_next  one-cycle pulse starting the next layer
module cim_func_stream
  import cim_func_pkg::*;
#(
  parameter int input_size  = 201,
  parameter int output_size = 512,
  parameter int xbar_size   = 256,
  parameter int in_width    = 16,
  parameter int out_width   = 8,
  parameter int v_cim_tiles = ceil_div(input_size, xbar_size),
  parameter int h_cim_tiles = ceil_div(output_size, xbar_size)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_start,
  input  logic                                         i_cim_busy,
  input  logic                                         i_next_busy,
  input  logic [4:0]                                   i_shift,
  input  logic [h_cim_tiles*v_cim_tiles*in_width-1:0]  i_data,
  output logic [$clog2(xbar_size)-1:0]                 o_cim_addr,
  output logic                                         o_busy,
  output logic [out_width-1:0]                         o_data,
  output logic                                         o_valid,
  input  logic                                         i_ready,
  output logic                                         o_start_next
);

  localparam int addr_w = $clog2(xbar_size);
  localparam int cnt_w  = (output_size > 1) ? $clog2(output_size) : 1;
  localparam int ht_w   = (h_cim_tiles > 1) ? $clog2(h_cim_tiles) : 1;
  localparam int tile_w = v_cim_tiles * in_width;

  t_cim_func_state      state;
  logic [cnt_w-1:0]     count;
  logic [ht_w-1:0]      h_tile;
  logic [4:0]           shift_q;
  logic [tile_w-1:0]    tile_sel;
  logic [out_width-1:0] requant_out;
  logic                 take;
  logic                 last;

  // Select the vertical tile group of the current horizontal tile.
  always_comb begin
    tile_sel = '0;
    for (int h = 0; h < h_cim_tiles; h++) begin
      if (h_tile == ht_w'(h)) tile_sel = i_data[h*tile_w +: tile_w];
    end
  end

  cim_requant #(
    .v_cim_tiles (v_cim_tiles),
    .in_width    (in_width),
    .out_width   (out_width)
  ) u_requant (
    .tiles  (tile_sel),
    .shift  (shift_q),
    .result (requant_out)
  );

  // Output register is free when empty or being drained this cycle.
  assign take = !o_valid || i_ready;
  assign last = (count == cnt_w'(output_size - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      h_tile       <= '0;
      shift_q      <= '0;
      o_cim_addr   <= '0;
      o_busy       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_start_next <= 1'b0;
    end else begin
      o_start_next <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            shift_q <= i_shift;
            o_busy  <= 1'b1;
            state   <= i_cim_busy ? WAIT : READ;
          end
        end
        WAIT: begin
          if (!i_cim_busy) state <= READ;
        end
        READ: begin
          if (take) begin
            o_data  <= requant_out;
            o_valid <= 1'b1;
            if (last) begin
              // Park the walk at the start so no address past the last
              // element is ever presented.
              count      <= '0;
              o_cim_addr <= '0;
              h_tile     <= '0;
              state      <= DRAIN;
            end else begin
              count <= count + 1'b1;
              if (o_cim_addr == addr_w'(xbar_size - 1)) begin
                o_cim_addr <= '0;
                h_tile     <= h_tile + 1'b1;
              end else begin
                o_cim_addr <= o_cim_addr + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (take) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= HANDOFF;
          end
        end
        HANDOFF: begin
          if (!i_next_busy) begin
            o_start_next <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_func_stream.sv
// Testbench for cim_func_stream, configured with three vertical tiles
// (input_size=600) and two horizontal tiles (output_size=512, xbar_size=256).
// A crossbar memory model feeds i_data from o_cim_addr; expected elements are
// computed from that memory with plain integer arithmetic.
module tb_cim_func_stream;

  localparam int IN_SZ  = 600;
  localparam int OUT_SZ = 512;
  localparam int X      = 256;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;
  localparam int V      = 3;
  localparam int H      = 2;
  localparam int BUDGET = 5000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_start;
  logic                  i_cim_busy;
  logic                  i_next_busy;
  logic [4:0]            i_shift;
  logic [H*V*IN_W-1:0]   i_data;
  logic [7:0]            o_cim_addr;
  logic                  o_busy;
  logic [OUT_W-1:0]      o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_start_next;

  int checks   = 0;
  int failures = 0;

  logic signed [IN_W-1:0] mem [H][V][X];
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_q[$];

  cim_func_stream #(
    .input_size  (IN_SZ),
    .output_size (OUT_SZ),
    .xbar_size   (X),
    .in_width    (IN_W),
    .out_width   (OUT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_cim_busy   (i_cim_busy),
    .i_next_busy  (i_next_busy),
    .i_shift      (i_shift),
    .i_data       (i_data),
    .o_cim_addr   (o_cim_addr),
    .o_busy       (o_busy),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_start_next (o_start_next)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Crossbar model: combinational read at the presented address.
  always_comb begin
    i_data = '0;
    for (int h = 0; h < H; h++)
      for (int v = 0; v < V; v++)
        i_data[(h*V+v)*IN_W +: IN_W] = mem[h][v][o_cim_addr];
  end

  // ---------------- reference model ----------------
  function automatic logic [OUT_W-1:0] model_elem(input int n, input int sh);
    longint s;
    s = 0;
    for (int v = 0; v < V; v++) s += longint'(mem[n / X][v][n % X]);
`ifdef CIM_FUNC_RELU_EN
    if (s < 0) s = 0;
`endif
    s = s >>> sh;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return OUT_W'(s);
  endfunction

  task automatic fill_exp_model(input int sh);
    exp_q.delete();
    for (int n = 0; n < OUT_SZ; n++) exp_q.push_back(model_elem(n, sh));
  endtask

  task automatic fill_exp_const(input int val);
    exp_q.delete();
    for (int n = 0; n < OUT_SZ; n++) exp_q.push_back(OUT_W'(val));
  endtask

  task automatic fill_mem_const(input int val);
    for (int h = 0; h < H; h++)
      for (int v = 0; v < V; v++)
        for (int a = 0; a < X; a++) mem[h][v][a] = IN_W'(val);
  endtask

  task automatic fill_mem_random(input int range);
    for (int h = 0; h < H; h++)
      for (int v = 0; v < V; v++)
        for (int a = 0; a < X; a++)
          mem[h][v][a] = IN_W'(int'($urandom_range(0, 2*range)) - range);
  endtask

  // Number of positions where got_q differs from exp_q (size differences excluded).
  function automatic int count_diffs(output int first);
    int d;
    d = 0;
    first = -1;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      if (got_q[k] !== exp_q[k]) begin
        d++;
        if (first < 0) first = k;
      end
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  // Runs one layer from the current state until one cycle after o_start_next,
  // recording accepted elements into got_q. ready_mode: 0 high, 1 toggling,
  // 2 random. start_mid_at>0 pulses a stray i_start (with a changed shift)
  // at that cycle. Entered and left just after a rising edge.
  task automatic collect_layer(input bit do_start, input int ready_mode,
                               input int next_busy_cycles, input int start_mid_at,
                               output int busy_cycles, output int stall_errs,
                               output int pulse_count, output int pulse_at,
                               output bit timed_out);
    int cyc, handoff;
    bit seen_busy, have_stall, finish_now;
    logic [OUT_W-1:0] stall_data;
    cyc = 0; handoff = 0; seen_busy = 0; have_stall = 0; finish_now = 0;
    stall_data = '0;
    busy_cycles = 0; stall_errs = 0; pulse_count = 0; pulse_at = -1; timed_out = 1;
    got_q.delete();
    i_start     = do_start;
    i_next_busy = (next_busy_cycles > 0);
    i_ready     = 1'b1;
    while (cyc < BUDGET) begin
      @(negedge clk);
      if (o_busy) begin
        busy_cycles++;
        seen_busy = 1;
      end else if (seen_busy) begin
        handoff++;
      end
      if (have_stall && o_data !== stall_data) stall_errs++;
      have_stall = o_valid && !i_ready;
      stall_data = o_data;
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_start_next) begin
        pulse_count++;
        if (pulse_at < 0) pulse_at = handoff;
      end
      if (finish_now) begin
        timed_out = 0;
        @(posedge clk); #1;
        break;
      end
      if (o_start_next) finish_now = 1;
      @(posedge clk); #1;
      cyc++;
      i_start = (cyc == start_mid_at);
      if (cyc == start_mid_at) i_shift = i_shift ^ 5'h07;
      case (ready_mode)
        1:       i_ready = cyc[0];
        2:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b1;
      endcase
      i_next_busy = (handoff < next_busy_cycles);
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    i_next_busy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_cim_addr !== 8'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", o_cim_addr); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_data: got %0d want 0", o_data); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_start_next !== 1'b0) begin failures++; $display("FAIL reset_start_next: got %b want 0", o_start_next); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_rate;
    int busy, stall, pulses, p_at, first, d;
    bit to;
    // Only vertical tile 0 carries 1, so every summed element is 1.
    fill_mem_const(0);
    for (int h = 0; h < H; h++) for (int a = 0; a < X; a++) mem[h][0][a] = 16'sd1;
    fill_exp_const(1);
    i_shift = 5'd0;
    collect_layer(1'b1, 0, 0, 0, busy, stall, pulses, p_at, to);
    checks++; if (to) begin failures++; $display("FAIL full_rate_timeout: no o_start_next within %0d cycles", BUDGET); end
    checks++; if (got_q.size() !== OUT_SZ) begin failures++; $display("FAIL full_rate_count: got %0d want %0d", got_q.size(), OUT_SZ); end
    d = count_diffs(first);
    checks++; if (d !== 0) begin failures++; $display("FAIL full_rate_data: %0d wrong, first idx %0d got %0d want 1", d, first, got_q[first]); end
    checks++; if (busy !== OUT_SZ + 1) begin failures++; $display("FAIL full_rate_cycles: got %0d want %0d", busy, OUT_SZ + 1); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL full_rate_pulses: got %0d want 1", pulses); end
    checks++; if (p_at !== 2) begin failures++; $display("FAIL full_rate_pulse_time: got %0d want 2", p_at); end
    checks++; if (o_cim_addr !== 8'd0) begin failures++; $display("FAIL full_rate_end_addr: got %0d want 0", o_cim_addr); end
  endtask

  task automatic test_arith;
    int vals[5]   = '{100, 100, -100, -100, -3};
    int shifts[5] = '{2, 0, 0, 31, 1};
`ifdef CIM_FUNC_RELU_EN
    int wants[5]  = '{75, 127, 0, 0, 0};
`else
    int wants[5]  = '{75, 127, -128, -1, -5};
`endif
    int busy, stall, pulses, p_at, first, d;
    bit to;
    for (int i = 0; i < 5; i++) begin
      fill_mem_const(vals[i]);
      fill_exp_const(wants[i]);
      i_shift = 5'(shifts[i]);
      collect_layer(1'b1, 0, 0, 0, busy, stall, pulses, p_at, to);
      d = count_diffs(first);
      checks++;
      if (to || got_q.size() !== OUT_SZ || d !== 0) begin
        failures++;
        $display("FAIL arith_case%0d: tiles=%0d shift=%0d got n=%0d first=%0d want n=%0d all %0d",
                 i, vals[i], shifts[i], got_q.size(), (got_q.size() > 0) ? $signed(got_q[0]) : 0,
                 OUT_SZ, wants[i]);
      end
    end
  endtask

  task automatic test_random_data;
    int busy, stall, pulses, p_at, first, d, sh;
    bit to;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin fill_mem_random(2000);  sh = $urandom_range(0, 5); end
      else        begin fill_mem_random(32000); sh = $urandom_range(10, 18); end
      fill_exp_model(sh);
      i_shift = 5'(sh);
      collect_layer(1'b1, 2, 0, 0, busy, stall, pulses, p_at, to);
      d = count_diffs(first);
      checks++;
      if (to || got_q.size() !== OUT_SZ || d !== 0) begin
        failures++;
        $display("FAIL random_data%0d: got n=%0d want n=%0d, %0d wrong, first idx %0d got %0d want %0d",
                 r, got_q.size(), OUT_SZ, d, first,
                 (first >= 0) ? got_q[first] : 8'd0, (first >= 0) ? exp_q[first] : 8'd0);
      end
      checks++; if (stall !== 0) begin failures++; $display("FAIL random_stall%0d: o_data changed %0d times while held, want 0", r, stall); end
    end
  endtask

  task automatic test_ready_toggle;
    int busy, stall, pulses, p_at, first, d;
    bit to;
    fill_mem_random(3000);
    fill_exp_model(3);
    i_shift = 5'd3;
    collect_layer(1'b1, 1, 0, 0, busy, stall, pulses, p_at, to);
    d = count_diffs(first);
    checks++; if (got_q.size() !== OUT_SZ) begin failures++; $display("FAIL toggle_count: got %0d want %0d", got_q.size(), OUT_SZ); end
    checks++; if (d !== 0) begin failures++; $display("FAIL toggle_data: %0d wrong, first idx %0d got %0d want %0d", d, first, got_q[first], exp_q[first]); end
    checks++; if (stall !== 0) begin failures++; $display("FAIL toggle_stall: o_data changed %0d times while held, want 0", stall); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL toggle_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_wait;
    int busy, stall, pulses, p_at, first, d, bad;
    bit to;
    fill_mem_random(1000);
    fill_exp_model(2);
    i_shift = 5'd2;
    i_cim_busy = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy !== 1'b1 || o_cim_addr !== 8'd0 || o_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wait_hold: %0d cycles not busy/addr0/idle out, want 0", bad); end
    i_cim_busy = 1'b0;
    collect_layer(1'b0, 0, 0, 0, busy, stall, pulses, p_at, to);
    d = count_diffs(first);
    checks++; if (got_q.size() !== OUT_SZ || d !== 0) begin failures++; $display("FAIL wait_data: got n=%0d want %0d, %0d wrong", got_q.size(), OUT_SZ, d); end
    // One WAIT cycle after release, then READ+DRAIN.
    checks++; if (busy !== OUT_SZ + 2) begin failures++; $display("FAIL wait_release_latency: busy cycles %0d want %0d", busy, OUT_SZ + 2); end
  endtask

  task automatic test_next_busy_and_restart;
    int busy, stall, pulses, p_at, first, d;
    bit to;
    fill_mem_random(1500);
    fill_exp_model(1);
    i_shift = 5'd1;
    // Stray i_start mid-stream with a different shift must be ignored.
    collect_layer(1'b1, 0, 5, 60, busy, stall, pulses, p_at, to);
    d = count_diffs(first);
    checks++; if (got_q.size() !== OUT_SZ || d !== 0) begin failures++; $display("FAIL restart_ignored_data: got n=%0d want %0d, %0d wrong", got_q.size(), OUT_SZ, d); end
    checks++; if (busy !== OUT_SZ + 1) begin failures++; $display("FAIL restart_ignored_cycles: got %0d want %0d", busy, OUT_SZ + 1); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL next_busy_pulses: got %0d want 1", pulses); end
    checks++; if (p_at !== 7) begin failures++; $display("FAIL next_busy_pulse_time: got %0d want 7", p_at); end
  endtask

  task automatic test_reset_mid;
    int n, cyc, busy, stall, pulses, p_at, first, d;
    bit to;
    fill_mem_random(2500);
    fill_exp_model(4);
    i_shift = 5'd4;
    i_start = 1'b1;
    n = 0; cyc = 0;
    while (n < 100 && cyc < BUDGET) begin
      @(negedge clk);
      if (o_valid && i_ready) n++;
      @(posedge clk); #1;
      i_start = 1'b0;
      cyc++;
    end
    checks++; if (n !== 100) begin failures++; $display("FAIL reset_mid_reach: got %0d elements want 100", n); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_cim_addr !== 8'd0 || o_busy !== 1'b0 || o_data !== '0 || o_valid !== 1'b0 || o_start_next !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_values: addr=%0d busy=%b data=%0d valid=%b start_next=%b want all 0",
               o_cim_addr, o_busy, o_data, o_valid, o_start_next);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    collect_layer(1'b1, 0, 0, 0, busy, stall, pulses, p_at, to);
    d = count_diffs(first);
    checks++; if (got_q.size() !== OUT_SZ || d !== 0) begin failures++; $display("FAIL reset_mid_restart: got n=%0d want %0d, %0d wrong, first idx %0d", got_q.size(), OUT_SZ, d, first); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_cim_busy = 1'b0;
    i_next_busy = 1'b0;
    i_shift = 5'd0;
    i_ready = 1'b1;
    fill_mem_const(0);
    test_reset;
    test_full_rate;
    test_arith;
    test_random_data;
    test_ready_toggle;
    test_wait;
    test_next_busy_and_restart;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
